pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL take parameter EXC_VECTOR, default 32'h00000020: redirect target for every exception except ERET.
REQ-002 SHALL take parameter WDOG_LIMIT, default 255: consecutive stall-request cycles that trip the watchdog; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port stallreq_if, input, 1: fetch stage requests a stall.
REQ-006 SHALL have port stallreq_id, input, 1: decode stage requests a stall.
REQ-007 SHALL have port stallreq_ex, input, 1: execute stage requests a stall.
REQ-008 SHALL have port stallreq_mem, input, 1: memory stage requests a stall.
REQ-009 SHALL have port excepttype_i, input, 32: exception code from MEM; zero means no exception.
REQ-010 SHALL have port cp0_epc_i, input, 32: current EPC, used as the ERET target.
REQ-011 SHALL have port stall, output, 6: per-stage hold; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-012 SHALL have port flush, output, 1: pipeline flush to all stage registers.
REQ-013 SHALL have port new_pc, output, 32: redirect address; valid only while flush=1.
REQ-014 SHALL have port stall_cycles_o, output, 16: saturating count of request-driven stall cycles.
REQ-015 SHALL have port wdog_o, output, 1: sticky watchdog flag.
REQ-016 SHALL have port ctrl_state_o, output, 2: current FSM state encoding.

Function
REQ-017 SHALL implement FSM states RUN=2'd0, FLUSH=2'd1, REFILL=2'd2; encoding 2'd3 SHALL return to RUN on the next edge.
REQ-018 In RUN with excepttype_i != 0, SHALL drive stall=6'b111111 combinationally, latch excepttype_i and cp0_epc_i, and go to FLUSH.
REQ-019 In RUN with excepttype_i == 0, stall SHALL be combinational from requests, highest stage winning: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-020 In FLUSH (exactly one cycle), SHALL drive flush=1 and stall=6'b000000, ignore requests and excepttype_i, then go to REFILL.
REQ-021 In FLUSH, new_pc SHALL be the latched EPC when the latched code is 32'h0000000e (ERET), else EXC_VECTOR.
REQ-022 In REFILL (exactly one cycle), SHALL ignore excepttype_i, derive stall from requests per REQ-019, hold flush=0, then go to RUN.
REQ-023 Outside FLUSH, flush SHALL be 0 and new_pc SHALL be 32'h00000000.
REQ-024 Exception latency: flush SHALL assert exactly one cycle after the edge that samples a nonzero excepttype_i in RUN.
REQ-025 When an exception and any stall request occur in the same RUN cycle, the exception SHALL win and the request SHALL neither count nor feed the watchdog.
REQ-026 stall_cycles_o SHALL increment by one on each edge where stall[0]=1 due to a request (RUN or REFILL), saturating at 16'hFFFF.
REQ-027 An internal 16-bit consecutive counter SHALL increment on each request-driven stall cycle and clear on any other cycle.
REQ-028 wdog_o SHALL set on the edge where the consecutive count reaches WDOG_LIMIT, and SHALL stay set until rst.

Reset
REQ-029 On rst=1 at a clock edge, SHALL set state=RUN, both counters=0, wdog_o=0, latched code and EPC=0.
REQ-030 While rst=1, SHALL drive stall=0, flush=0 and new_pc=0 regardless of inputs, including mid-FLUSH or mid-REFILL.

Structure
REQ-031 SHALL place state encodings, stall patterns and the ERET code 32'h0000000e in the shared define include, beside the Stop/NoStop definitions.
REQ-032 SHALL be a single module with no sub-modules; the stall priority encoder SHALL remain inline.

Verification
REQ-033 Bench SHALL drive stallreq_ex=1 in RUN -> stall=6'b001111 the same cycle, and stall_cycles_o +1 per cycle.
REQ-034 Bench SHALL drive excepttype_i=32'h00000008 -> stall=6'b111111 that cycle; next cycle flush=1 and new_pc=32'h00000020; then one REFILL cycle, then RUN.
REQ-035 Bench SHALL drive excepttype_i=32'h0000000e with cp0_epc_i=32'h00001234 -> flush=1 and new_pc=32'h00001234 one cycle later.
REQ-036 Bench SHALL drive stallreq_mem=1 and excepttype_i=32'h0000000c together -> exception path is taken and stall_cycles_o is unchanged.
REQ-037 Bench SHALL set WDOG_LIMIT=4 and hold stallreq_id for 4 cycles -> wdog_o=1 after the 4th edge; a 3-cycle request followed by a gap SHALL leave wdog_o=0.
REQ-038 Bench SHALL assert rst during FLUSH -> flush=0 the same cycle, and next edge gives state=RUN with counters=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings for the pipeline controller
//
// Purpose: holds the Stop/NoStop levels, FSM state encodings, per-stage
// stall patterns and the ERET exception code used by pipeline_ctrl.
// Ports: none (package).

package pipeline_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2,
        ST_BAD    = 2'd3
    } ctrl_state_t;

    // Stall vector bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_ERET  = 32'h0000000e;

endpackage

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for a 5-stage pipeline
//
// Purpose: arbitrates per-stage stall requests, converts a MEM-stage
// exception into a one-cycle flush with redirect address, counts
// request-driven stall cycles and raises a sticky watchdog flag when
// stall requests persist for WDOG_LIMIT consecutive cycles.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stallreq_if/id/ex/mem - per-stage stall requests
//   excepttype_i        - exception code from MEM (0 = none)
//   cp0_epc_i           - EPC, redirect target for ERET
//   stall[5:0]          - per-stage hold (PC, IF, ID, EX, MEM, WB)
//   flush, new_pc       - pipeline flush and redirect address
//   stall_cycles_o      - saturating request-driven stall cycle count
//   wdog_o              - sticky watchdog flag
//   ctrl_state_o        - current FSM state

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int          WDOG_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [15:0] stall_cycles_o,
    output logic        wdog_o,
    output logic [1:0]  ctrl_state_o
);

    // The watchdog trips when the cycle being counted is the LIMIT-th one,
    // i.e. the counter already holds LIMIT-1 before the edge.
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [31:0] exc_code;
    logic [31:0] exc_epc;
    logic [15:0] cons_cnt;
    logic [5:0]  req_pattern;
    logic        any_req;
    logic        req_stall;
    logic        take_exc;

    // Priority encoder: the deepest requesting stage wins because holding
    // it implies holding every earlier stage too.
    always_comb begin
        req_pattern = STALL_NONE;
        if (stallreq_mem == STOP) begin
            req_pattern = STALL_MEM;
        end else if (stallreq_ex == STOP) begin
            req_pattern = STALL_EX;
        end else if (stallreq_id == STOP) begin
            req_pattern = STALL_ID;
        end else if (stallreq_if == STOP) begin
            req_pattern = STALL_IF;
        end
    end

    assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

    always_comb begin
        state_next = state;
        stall      = STALL_NONE;
        flush      = NO_STOP;
        new_pc     = 32'h00000000;
        req_stall  = 1'b0;
        take_exc   = 1'b0;
        case (state)
            ST_RUN: begin
                if (excepttype_i != 32'h00000000) begin
                    // Exception outranks every request: freeze all stages
                    // and do not let the request count.
                    stall      = STALL_ALL;
                    take_exc   = 1'b1;
                    state_next = ST_FLUSH;
                end else begin
                    stall     = req_pattern;
                    req_stall = any_req;
                end
            end
            ST_FLUSH: begin
                flush      = STOP;
                new_pc     = (exc_code == EXC_ERET) ? exc_epc : EXC_VECTOR;
                state_next = ST_REFILL;
            end
            ST_REFILL: begin
                stall      = req_pattern;
                req_stall  = any_req;
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        // Reset must silence the outputs even in the cycle it is asserted,
        // before the synchronous state update takes effect.
        if (rst) begin
            stall  = STALL_NONE;
            flush  = NO_STOP;
            new_pc = 32'h00000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            exc_code       <= 32'h00000000;
            exc_epc        <= 32'h00000000;
            stall_cycles_o <= 16'h0000;
            cons_cnt       <= 16'h0000;
            wdog_o         <= 1'b0;
        end else begin
            state <= state_next;
            if (take_exc) begin
                exc_code <= excepttype_i;
                exc_epc  <= cp0_epc_i;
            end
            if (req_stall) begin
                if (stall_cycles_o != 16'hFFFF) begin
                    stall_cycles_o <= stall_cycles_o + 16'h0001;
                end
                if (cons_cnt != 16'hFFFF) begin
                    cons_cnt <= cons_cnt + 16'h0001;
                end
                if (cons_cnt >= WDOG_LAST) begin
                    wdog_o <= 1'b1;
                end
            end else begin
                cons_cnt <= 16'h0000;
            end
        end
    end

    assign ctrl_state_o = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl

module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cycles_o;
    logic        wdog_o;
    logic [1:0]  ctrl_state_o;

    int checks;
    int errors;

    pipeline_ctrl #(
        .EXC_VECTOR(32'h00000020),
        .WDOG_LIMIT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excepttype_i  (excepttype_i),
        .cp0_epc_i     (cp0_epc_i),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles_o(stall_cycles_o),
        .wdog_o        (wdog_o),
        .ctrl_state_o  (ctrl_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst = 1'b1;
        // Busy inputs during reset must not leak through.
        stallreq_mem = 1'b1;
        excepttype_i = 32'h8;
        #1;
        check("rst_stall", {26'h0, stall}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_newpc", new_pc, 32'h0);
        tick();
        tick();
        check("rst_state", {30'h0, ctrl_state_o}, 32'd0);
        check("rst_cnt", {16'h0, stall_cycles_o}, 32'd0);
        check("rst_wdog", {31'h0, wdog_o}, 32'd0);
        rst = 1'b0;
        clear_inputs();

        // Priority encoder patterns (no edge taken, so nothing counts).
        #1;
        check("pri_none", {26'h0, stall}, 32'h00);
        stallreq_if = 1'b1; #1;
        check("pri_if", {26'h0, stall}, 32'h03);
        stallreq_id = 1'b1; #1;
        check("pri_id", {26'h0, stall}, 32'h07);
        stallreq_ex = 1'b1; stallreq_mem = 1'b1; #1;
        check("pri_mem", {26'h0, stall}, 32'h1f);
        clear_inputs();

        // Execute stall for 3 cycles, then a gap: counts 1..3, no watchdog.
        stallreq_ex = 1'b1; #1;
        check("ex_stall", {26'h0, stall}, 32'h0f);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("ex_cnt", {16'h0, stall_cycles_o}, 32'(i));
        end
        stallreq_ex = 1'b0; #1;
        check("gap_stall", {26'h0, stall}, 32'h00);
        tick();
        check("gap_cnt", {16'h0, stall_cycles_o}, 32'd3);
        check("gap_wdog", {31'h0, wdog_o}, 32'd0);

        // Ordinary exception: full freeze, flush to vector, refill, run.
        excepttype_i = 32'h8; #1;
        check("exc_stall", {26'h0, stall}, 32'h3f);
        check("exc_noflush", {31'h0, flush}, 32'd0);
        tick();
        clear_inputs();
        stallreq_mem = 1'b1; #1;
        check("fl_state", {30'h0, ctrl_state_o}, 32'd1);
        check("fl_flush", {31'h0, flush}, 32'd1);
        check("fl_newpc", new_pc, 32'h20);
        check("fl_stall", {26'h0, stall}, 32'h00);
        stallreq_mem = 1'b0;
        tick();
        check("rf_state", {30'h0, ctrl_state_o}, 32'd2);
        check("rf_flush", {31'h0, flush}, 32'd0);
        check("rf_newpc", new_pc, 32'h0);
        tick();
        check("run_state", {30'h0, ctrl_state_o}, 32'd0);
        check("exc_cnt", {16'h0, stall_cycles_o}, 32'd3);

        // ERET: redirect to latched EPC; REFILL honours requests, ignores exceptions.
        excepttype_i = 32'h0000000e;
        cp0_epc_i    = 32'h00001234;
        tick();
        clear_inputs(); #1;
        check("eret_flush", {31'h0, flush}, 32'd1);
        check("eret_newpc", new_pc, 32'h00001234);
        tick();
        stallreq_id  = 1'b1;
        excepttype_i = 32'h8; #1;
        check("rf_req_stall", {26'h0, stall}, 32'h07);
        tick();
        clear_inputs(); #1;
        check("rf_ign_exc", {30'h0, ctrl_state_o}, 32'd0);
        check("rf_cnt", {16'h0, stall_cycles_o}, 32'd4);

        // Exception and request together: exception wins, no count.
        stallreq_mem = 1'b1;
        excepttype_i = 32'h0000000c; #1;
        check("both_stall", {26'h0, stall}, 32'h3f);
        tick();
        clear_inputs(); #1;
        check("both_state", {30'h0, ctrl_state_o}, 32'd1);
        check("both_newpc", new_pc, 32'h20);
        check("both_cnt", {16'h0, stall_cycles_o}, 32'd4);
        tick();
        tick();
        check("both_run", {30'h0, ctrl_state_o}, 32'd0);

        // Watchdog with limit 4: trips on the 4th consecutive edge, then sticks.
        stallreq_id = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("wd_flag", {31'h0, wdog_o}, (i == 4) ? 32'd1 : 32'd0);
        end
        stallreq_id = 1'b0;
        tick();
        check("wd_sticky", {31'h0, wdog_o}, 32'd1);
        check("wd_cnt", {16'h0, stall_cycles_o}, 32'd8);

        // Reset in the middle of FLUSH.
        excepttype_i = 32'h8;
        tick();
        clear_inputs(); #1;
        check("rf_pre_flush", {31'h0, flush}, 32'd1);
        rst = 1'b1; #1;
        check("rfl_flush", {31'h0, flush}, 32'd0);
        check("rfl_newpc", new_pc, 32'h0);
        check("rfl_stall", {26'h0, stall}, 32'h0);
        tick();
        check("rfl_state", {30'h0, ctrl_state_o}, 32'd0);
        check("rfl_cnt", {16'h0, stall_cycles_o}, 32'd0);
        check("rfl_wdog", {31'h0, wdog_o}, 32'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
